// File: rtl/chan_counter_pkg.sv
// Shared types for the channel counter bank: config field selects, overflow
// modes and the read-port state machine encoding.
package chan_counter_pkg;

  typedef enum logic [1:0] {
    CFG_LOAD  = 2'd0,
    CFG_STEP  = 2'd1,
    CFG_LIMIT = 2'd2,
    CFG_MODE  = 2'd3
  } cfg_sel_e;

  typedef enum logic [1:0] {
    MODE_WRAP = 2'd0,
    MODE_SAT  = 2'd1,
    MODE_HOLD = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/chan_counter_cell.sv
// One counter channel: count/step/limit/mode registers, overflow compare,
// registered terminal-count pulse and sticky saturation flag.
module chan_counter_cell
  import chan_counter_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int          STEP_W  = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [1:0]       i_sel,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_tick,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc,
  output logic             o_sat
);

  logic [WIDTH-1:0]  r_count;
  logic [WIDTH-1:0]  r_limit;
  logic [STEP_W-1:0] r_step;
  mode_e             r_mode;
  logic              r_tc;
  logic              r_sat;
  logic [WIDTH:0]    w_sum;
  logic              w_over;

  // One extra bit so count + step can never alias back below the limit.
  assign w_sum  = {1'b0, r_count} + (WIDTH+1)'(r_step);
  assign w_over = w_sum > {1'b0, r_limit};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= WIDTH'(RST_VAL);
      r_step  <= STEP_W'(1);
      r_limit <= '1;
      r_mode  <= MODE_WRAP;
      r_tc    <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (i_we) begin
        // A write always wins over a same-cycle tick; that tick is lost.
        case (cfg_sel_e'(i_sel))
          CFG_LOAD: begin
            r_count <= i_wdata;
            r_sat   <= 1'b0;
          end
          CFG_STEP:  r_step  <= i_wdata[STEP_W-1:0];
          CFG_LIMIT: r_limit <= i_wdata;
          default:   r_mode  <= mode_e'(i_wdata[1:0]);
        endcase
      end else if (i_tick && (r_mode == MODE_WRAP || r_mode == MODE_SAT)) begin
        if (!w_over) begin
          r_count <= w_sum[WIDTH-1:0];
        end else if (r_mode == MODE_WRAP) begin
          r_count <= '0;
          r_tc    <= 1'b1;
        end else begin
          r_count <= r_limit;
          r_sat   <= 1'b1;
          r_tc    <= 1'b1;
        end
      end
    end
  end

  assign o_count = r_count;
  assign o_tc    = r_tc;
  assign o_sat   = r_sat;

endmodule

// File: rtl/chan_counter_bank.sv
// Multi-channel event counter bank: config write decode, per-channel cells,
// and a one-deep valid/ready read port returning a count snapshot.
module chan_counter_bank
  import chan_counter_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter int          WIDTH   = 8,
  parameter int          STEP_W  = 4,
  parameter int unsigned RST_VAL = 0,
  localparam int         AW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [1:0]        cfg_sel,
  input  logic [WIDTH-1:0]  cfg_wdata,
  input  logic [NUM_CH-1:0] tick,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [AW-1:0]     rd_req_addr,
  output logic              rd_rsp_valid,
  input  logic              rd_rsp_ready,
  output logic [WIDTH-1:0]  rd_rsp_data,
  output logic [NUM_CH-1:0] tc,
  output logic [NUM_CH-1:0] sat
);

  logic [NUM_CH-1:0]            w_we;
  logic [NUM_CH-1:0][WIDTH-1:0] w_counts;
  logic [WIDTH-1:0]             w_rd_data;
  logic                         w_accept;
  rd_state_e                    r_state;
  rd_state_e                    w_next;
  logic [WIDTH-1:0]             r_rsp_data;

  // Addresses past the last channel match no cell, so those writes vanish.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_we[g] = cfg_we && (cfg_addr == AW'(g));

    chan_counter_cell #(
      .WIDTH   (WIDTH),
      .STEP_W  (STEP_W),
      .RST_VAL (RST_VAL)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we[g]),
      .i_sel   (cfg_sel),
      .i_wdata (cfg_wdata),
      .i_tick  (tick[g]),
      .o_count (w_counts[g]),
      .o_tc    (tc[g]),
      .o_sat   (sat[g])
    );
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_req_addr == AW'(i)) w_rd_data = w_counts[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= RD_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RD_IDLE: if (rd_req_valid) w_next = RD_RESP;
      default: if (rd_rsp_ready) w_next = rd_req_valid ? RD_RESP : RD_IDLE;
    endcase
  end

  always_comb begin
    rd_req_ready = 1'b1;
    rd_rsp_valid = 1'b0;
    if (r_state == RD_RESP) begin
      rd_req_ready = rd_rsp_ready;
      rd_rsp_valid = 1'b1;
    end
  end

  assign w_accept = rd_req_valid && rd_req_ready;

  // Snapshot taken from the pre-update count; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst)           r_rsp_data <= '0;
    else if (w_accept) r_rsp_data <= w_rd_data;
  end

  assign rd_rsp_data = r_rsp_data;

endmodule

// File: tb/tb_chan_counter_bank.sv
// Scoreboard bench for chan_counter_bank: directed scenarios then random traffic
// against a behavioural model of the counter rules and read port.
module tb_chan_counter_bank;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;
  localparam int AW     = 2;
  localparam longint MASK  = (64'd1 << WIDTH) - 1;
  localparam longint SMASK = (64'd1 << STEP_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [1:0]        cfg_sel = '0;
  logic [WIDTH-1:0]  cfg_wdata = '0;
  logic [NUM_CH-1:0] tick = '0;
  logic              rd_req_valid = 1'b0;
  logic              rd_req_ready;
  logic [AW-1:0]     rd_req_addr = '0;
  logic              rd_rsp_valid;
  logic              rd_rsp_ready = 1'b0;
  logic [WIDTH-1:0]  rd_rsp_data;
  logic [NUM_CH-1:0] tc;
  logic [NUM_CH-1:0] sat;

  chan_counter_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .STEP_W(STEP_W), .RST_VAL(0)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .tick(tick), .rd_req_valid(rd_req_valid),
    .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr), .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data), .tc(tc), .sat(sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  longint m_cnt [NUM_CH];
  longint m_step[NUM_CH];
  longint m_lim [NUM_CH];
  int     m_mode[NUM_CH];
  logic [NUM_CH-1:0] m_tc;
  logic [NUM_CH-1:0] m_sat;
  bit     m_busy;
  longint exp_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: applies the counter rules to the inputs seen at each edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_cnt[c] = 0; m_step[c] = 1; m_lim[c] = MASK; m_mode[c] = 0;
      end
      m_tc = '0; m_sat = '0; m_busy = 1'b0;
      exp_q.delete();
    end else begin
      if (rd_req_valid && (!m_busy || rd_rsp_ready)) begin
        exp_q.push_back((int'(rd_req_addr) < NUM_CH) ? m_cnt[rd_req_addr] : 0);
        m_busy = 1'b1;
      end else if (m_busy && rd_rsp_ready) begin
        m_busy = 1'b0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        longint sum;
        m_tc[c] = 1'b0;
        if (cfg_we && int'(cfg_addr) == c) begin
          case (cfg_sel)
            2'd0: begin m_cnt[c] = cfg_wdata; m_sat[c] = 1'b0; end
            2'd1: m_step[c] = cfg_wdata & SMASK;
            2'd2: m_lim[c] = cfg_wdata;
            default: m_mode[c] = cfg_wdata & 3;
          endcase
        end else if (tick[c] && m_mode[c] < 2) begin
          sum = m_cnt[c] + m_step[c];
          if (sum <= m_lim[c]) m_cnt[c] = sum;
          else if (m_mode[c] == 0) begin m_cnt[c] = 0; m_tc[c] = 1'b1; end
          else begin m_cnt[c] = m_lim[c]; m_sat[c] = 1'b1; m_tc[c] = 1'b1; end
        end
      end
    end
  end

  // Monitor: compares every presented response against the scoreboard front.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rsp_valid", rd_rsp_valid, m_busy);
      chk("req_ready", rd_req_ready, (!m_busy || rd_rsp_ready));
      chk("tc", tc, m_tc);
      chk("sat", sat, m_sat);
      if (rd_rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_data at %0t: got %0d with no response expected", $time, rd_rsp_data);
        end else begin
          chk("rsp_data", rd_rsp_data, exp_q[0]);
          if (rd_rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic we, input int a, input int s, input int d,
                     input logic [NUM_CH-1:0] t, input logic rv, input int ra, input logic rr);
    cfg_we = we; cfg_addr = AW'(a); cfg_sel = 2'(s); cfg_wdata = WIDTH'(d);
    tick = t; rd_req_valid = rv; rd_req_addr = AW'(ra); rd_rsp_ready = rr;
    @(posedge clk); #1;
  endtask

  task automatic wr(input int ch, input int s, input int d);
    cyc(1'b1, ch, s, d, '0, 1'b0, 0, 1'b1);
  endtask

  task automatic rd(input int ch);
    cyc(1'b0, 0, 0, 0, '0, 1'b1, ch, 1'b1);
    cyc(1'b0, 0, 0, 0, '0, 1'b0, 0, 1'b1);
  endtask

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    chk("rst_rsp_data", rd_rsp_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", rd_req_ready, 1);
    @(posedge clk); #1;

    rd(2);

    wr(0, 2, 10); wr(0, 1, 3); wr(0, 3, 0); wr(0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(1'b0, 0, 0, 0, 4'b0001, 1'b0, 0, 1'b1);
    rd(0);

    wr(1, 3, 1); wr(1, 2, 200); wr(1, 1, 15); wr(1, 0, 190);
    for (int k = 0; k < 2; k++) cyc(1'b0, 0, 0, 0, 4'b0010, 1'b0, 0, 1'b1);
    rd(1);
    wr(1, 0, 5);

    cyc(1'b1, 3, 0, 'h55, 4'b1000, 1'b0, 0, 1'b1);
    rd(3);

    wr(0, 0, 7);
    cyc(1'b0, 0, 0, 0, '0, 1'b1, 0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 0, 0, 0, 4'b0001, 1'b0, 0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 0, 0, 0, '0, 1'b1, k + 1, 1'b1);
    cyc(1'b0, 0, 0, 0, '0, 1'b0, 0, 1'b1);

    wr(2, 3, 2);
    for (int k = 0; k < 5; k++) cyc(1'b0, 0, 0, 0, 4'b0100, 1'b0, 0, 1'b1);
    rd(2);

    cyc(1'b0, 0, 0, 0, 4'b1111, 1'b1, 2, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 0, 0, 0, '0, 1'b0, 0, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) rd(c);

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      cyc(($urandom_range(0, 3) == 0), $urandom_range(0, NUM_CH - 1), $urandom_range(0, 3),
          ($urandom_range(0, 1) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 255),
          NUM_CH'($urandom), $urandom_range(0, 1), $urandom_range(0, NUM_CH - 1),
          ($urandom_range(0, 3) != 0));
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cyc(1'b0, 0, 0, 0, '0, 1'b0, 0, 1'b1);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
